// File: rtl/tf_fetch_ctrl.sv
// rtl/tf_fetch_ctrl.sv - twiddle-factor ROM fetch sequencer with read tracking pipe
// Optional TF_STAGE_GAP_EN inserts one idle cycle between consecutive stages.
module tf_fetch_ctrl #(
  parameter int STAGE_NUM  = 4,
  parameter int GRP_NUM    = 16,
  parameter int ROM_LAT    = 1,
  parameter int PIPE_DEPTH = 3,
  parameter int ADDR_W     = 6,
  parameter int STG_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              tf_rd_en,
  output logic [ADDR_W-1:0] tf_addr,
  output logic              tf_valid_out,
  output logic [STG_W-1:0]  tf_stage_out,
  output logic              tf_last_out
);

  localparam int TRK_D = ROM_LAT + PIPE_DEPTH;
  localparam int GRP_W = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1;

`ifdef TF_STAGE_GAP_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_GAP, S_DRAIN, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;
`endif

  state_t                     state, state_n;
  logic [STG_W-1:0]           stage_cnt, stage_n;
  logic [GRP_W-1:0]           grp_cnt, grp_n;
  logic                       stage_last, grp_last, last_rd;
  logic [TRK_D-1:0]           trk_v, trk_l;
  logic [TRK_D-1:0][STG_W-1:0] trk_s;

  assign stage_last = (stage_cnt == STG_W'(STAGE_NUM - 1));
  assign grp_last   = (grp_cnt == GRP_W'(GRP_NUM - 1));
  assign last_rd    = tf_rd_en && stage_last && grp_last;

  always_comb begin
    state_n = state;
    stage_n = stage_cnt;
    grp_n   = grp_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_FETCH;
          stage_n = '0;
          grp_n   = '0;
        end
      end
      S_FETCH: begin
        if (grp_last) begin
          grp_n = '0;
          if (stage_last) begin
            state_n = S_DRAIN;
            stage_n = '0;
          end else begin
            stage_n = stage_cnt + STG_W'(1);
`ifdef TF_STAGE_GAP_EN
            state_n = S_GAP;
`endif
          end
        end else begin
          grp_n = grp_cnt + GRP_W'(1);
        end
      end
`ifdef TF_STAGE_GAP_EN
      S_GAP:   state_n = S_FETCH;
`endif
      // The pipe is empty only once the last-flagged bundle has left the head.
      S_DRAIN: if (trk_v == '0) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort) begin
      state_n = S_IDLE;
      stage_n = '0;
      grp_n   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      stage_cnt <= '0;
      grp_cnt   <= '0;
      tf_rd_en  <= 1'b0;
      tf_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      stage_cnt <= stage_n;
      grp_cnt   <= grp_n;
      tf_rd_en  <= (state_n == S_FETCH);
      tf_addr   <= (state_n == S_FETCH) ?
                   ADDR_W'(stage_n) * ADDR_W'(GRP_NUM) + ADDR_W'(grp_n) : '0;
      busy      <= (state_n != S_IDLE) && (state_n != S_DONE);
      done      <= (state_n == S_DONE);
    end
  end

  // Tracking pipe mirrors ROM latency plus the TF delay registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_v <= '0;
      trk_l <= '0;
      trk_s <= '0;
    end else if (abort) begin
      trk_v <= '0;
      trk_l <= '0;
      trk_s <= '0;
    end else begin
      for (int i = TRK_D - 1; i > 0; i--) begin
        trk_v[i] <= trk_v[i-1];
        trk_l[i] <= trk_l[i-1];
        trk_s[i] <= trk_s[i-1];
      end
      trk_v[0] <= tf_rd_en;
      trk_l[0] <= last_rd;
      trk_s[0] <= tf_rd_en ? stage_cnt : '0;
    end
  end

  assign tf_valid_out = trk_v[TRK_D-1];
  assign tf_last_out  = trk_l[TRK_D-1];
  assign tf_stage_out = trk_s[TRK_D-1];

endmodule

// File: tb/tb_tf_fetch_ctrl.sv
// tb/tb_tf_fetch_ctrl.sv - self-checking bench for tf_fetch_ctrl
module tb_tf_fetch_ctrl;

  localparam int S   = 4;
  localparam int G   = 16;
  localparam int RL  = 1;
  localparam int PD  = 3;
  localparam int AW  = 6;
  localparam int SW  = 2;
  localparam int N   = S * G;
  localparam int LAT = RL + PD;
`ifdef TF_STAGE_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif
  localparam int MAXC = 160;
  localparam int OW   = 5 + AW + SW;

  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic abort = 0;
  logic busy, done, tf_rd_en, tf_valid_out, tf_last_out;
  logic [AW-1:0] tf_addr;
  logic [SW-1:0] tf_stage_out;

  int total = 0;
  int bad = 0;

  logic [OW-1:0] exp_w [MAXC];

  tf_fetch_ctrl #(
    .STAGE_NUM(S), .GRP_NUM(G), .ROM_LAT(RL), .PIPE_DEPTH(PD),
    .ADDR_W(AW), .STG_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .tf_rd_en(tf_rd_en), .tf_addr(tf_addr),
    .tf_valid_out(tf_valid_out), .tf_stage_out(tf_stage_out),
    .tf_last_out(tf_last_out)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] obs_w();
    return {busy, done, tf_rd_en, tf_addr, tf_valid_out, tf_stage_out, tf_last_out};
  endfunction

  // Cycle in which the final bundle appears at the pipe output (start sampled in cycle 0).
  function automatic int last_cycle();
    return 1 + (N - 1) + GAP * ((N - 1) / G) + LAT;
  endfunction

  // Builds the expected per-cycle output trace of one pass from the read schedule.
  task automatic build_model(input int abort_at);
    int ic, vc, lc;
    logic [AW-1:0] a;
    logic [SW-1:0] s;
    for (int c = 0; c < MAXC; c++) exp_w[c] = '0;
    if (abort_at == 0) return;
    lc = last_cycle();
    for (int k = 0; k < N; k++) begin
      ic = 1 + k + GAP * (k / G);
      vc = ic + LAT;
      a  = AW'(k);
      s  = SW'(k / G);
      exp_w[ic][OW-3] = 1'b1;
      exp_w[ic][SW+AW+1:SW+2] = a;
      exp_w[vc][SW+1] = 1'b1;
      exp_w[vc][SW:1] = s;
      exp_w[vc][0] = (k == N - 1);
    end
    for (int c = 1; c <= lc + 1; c++) exp_w[c][OW-1] = 1'b1;
    exp_w[lc + 2][OW-2] = 1'b1;
    if (abort_at > 0)
      for (int c = abort_at + 1; c < MAXC; c++) exp_w[c] = '0;
  endtask

  // Called right after a rising edge; cycle 0 carries the start pulse.
  task automatic run_pass(input string tag, input int abort_at, input int extra_at, input int ncyc);
    int n, reads, exp_reads;
    n = (ncyc > 0) ? ncyc : last_cycle() + 4;
    build_model(abort_at);
    reads = 0;
    exp_reads = 0;
    for (int c = 0; c < n; c++) begin
      start = (c == 0) || (c == extra_at);
      abort = (c == abort_at);
      if (exp_w[c][OW-3]) exp_reads++;
      @(negedge clk);
      if (tf_rd_en) reads++;
      total++;
      if (obs_w() !== exp_w[c]) begin
        bad++;
        $display("FAIL %s cycle %0d: got busy/done/rd/addr/v/stg/last=%b_%b_%b_%0d_%b_%0d_%b want %b_%b_%b_%0d_%b_%0d_%b",
                 tag, c, busy, done, tf_rd_en, tf_addr, tf_valid_out, tf_stage_out, tf_last_out,
                 exp_w[c][OW-1], exp_w[c][OW-2], exp_w[c][OW-3], exp_w[c][SW+AW+1:SW+2],
                 exp_w[c][SW+1], exp_w[c][SW:1], exp_w[c][0]);
      end
      @(posedge clk);
      #1;
    end
    start = 0;
    abort = 0;
    total++;
    if (reads !== exp_reads) begin
      bad++;
      $display("FAIL %s read_count: got %0d want %0d", tag, reads, exp_reads);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs_w() !== '0) begin
      bad++;
      $display("FAIL reset_hold: got %h want 0", obs_w());
    end
    rst = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (obs_w() !== '0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: got %h want 0", c, obs_w());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_pass();
    run_pass("full_pass", -1, -1, 0);
  endtask

  task automatic test_start_while_busy();
    run_pass("start_busy", -1, 10, 0);
    run_pass("start_in_done", -1, last_cycle() + 2, 0);
  endtask

  task automatic test_abort();
    run_pass("abort_mid", 20, -1, 25);
    run_pass("restart_after_abort", -1, -1, 0);
  endtask

  task automatic test_abort_start_idle();
    start = 1;
    abort = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (tf_rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL abort_start_idle cycle %0d: got rd=%b busy=%b done=%b want 0 0 0",
                 c, tf_rd_en, busy, done);
      end
      @(posedge clk);
      #1;
      start = 0;
      abort = 0;
    end
  endtask

  task automatic test_reset_mid_pass();
    run_pass("pre_reset", -1, -1, 30);
    rst = 1;
    #1;
    total++;
    if (obs_w() !== '0) begin
      bad++;
      $display("FAIL reset_mid_pass: got %h want 0", obs_w());
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    run_pass("after_reset", -1, -1, 0);
  endtask

  task automatic test_random();
    int ab, ex, lc;
    lc = last_cycle();
    for (int it = 0; it < 6; it++) begin
      ab = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, lc + 2));
      ex = int'($urandom_range(1, lc + 2));
      if (ab >= 0 && ex > ab) ex = -1;
      run_pass($sformatf("random%0d", it), ab, ex, 0);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_start_while_busy();
    test_abort();
    test_abort_start_idle();
    test_reset_mid_pass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
